fifo_wr_stream_if: RTL
======================

Name: fifo_wr_stream_if

Overview:
- Write-side front end of the async FIFO, in the W_CLK domain.
- Takes a valid/ready producer stream into a 2-entry skid buffer and drives the write-pointer block (w_inc) and the dual-port memory write data (w_wdata).
- Converts the write pointer and the synchronized read pointer to binary to produce a fill level and a registered almost-full flag for upstream throttling.

Parameters:
- DATA_WIDTH, 8, width of stream and FIFO memory word.
- ADDR_WIDTH, 3, FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AF_THRESH, 6, fill level at or above which w_almost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
- W_CLK  input  1  write-domain clock.
- W_RST  input  1  reset, asynchronous, active-low.
- s_data  input  DATA_WIDTH  producer data.
- s_valid  input  1  producer data valid.
- s_ready  output  1  skid buffer can accept; registered.
- w_full  input  1  registered full flag from the write-pointer block.
- w_ptr  input  ADDR_WIDTH+1  Gray write pointer from the write-pointer block.
- wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into W_CLK.
- w_inc  output  1  push strobe to the write-pointer block and memory write enable.
- w_wdata  output  DATA_WIDTH  memory write data; valid whenever w_inc=1.
- w_level  output  ADDR_WIDTH+1  registered FIFO occupancy as seen from the write side, 0..2**ADDR_WIDTH.
- w_almost_full  output  1  registered; w_level >= AF_THRESH.
- w_push_cnt  output  16  registered count of pushes; wraps modulo 2**16.

Behaviour:
- Reset values (async, W_RST=0): skid count=0, both entries=0, s_ready=0, w_level=0, w_almost_full=0, w_push_cnt=0.
  - First cycle after reset release: s_ready=1.
- Skid buffer: 2 entries, head/tail, count 0..2.
  - accept = s_valid & s_ready.
  - push = w_inc = (count!=0) & ~w_full; combinational from registered state only, with no path from s_valid.
  - w_wdata = head entry data, combinational from registers.
  - s_ready next = (count_next < 2), registered.
- Count update:
  - accept & ~push: +1.
  - push & ~accept: -1.
  - both in the same cycle: unchanged; the tail write and head advance both occur.
  - neither: unchanged.
- Latency: a word accepted in cycle N is pushed no earlier than cycle N+1; with w_full=0 it is pushed exactly at N+1 when the buffer is empty at N.
- Throughput: sustained 1 word/clock when w_full=0.
- Ordering: strict FIFO order; no drops or duplicates.
- w_full semantics: w_full rises the cycle after the push that fills the FIFO, so gating w_inc with the registered w_full never overfills it.
  - While w_full=1: w_inc=0 and the buffer holds its data.
  - s_ready falls once count reaches 2.
- Level computation:
  - wbin = gray2bin(w_ptr); rbin = gray2bin(wq2_rptr).
  - level_c = (wbin - rbin) modulo 2**(ADDR_WIDTH+1); this is correct across pointer wrap.
  - w_level <= level_c each cycle (1-cycle lag behind pointers).
  - w_almost_full <= (level_c >= AF_THRESH).
  - Level is conservative because wq2_rptr is stale, so it may over-report, never under-report.
- w_push_cnt increments by 1 on every w_inc cycle.
- Reset mid-operation: all buffered words are discarded; the pointer block is reset by the same W_RST.
- The data path does not depend on X on s_data when s_valid=0; entries are loaded only on accept.

Decomposition:
- Shared package fifo_pkg: depth/pointer-width constants derived from ADDR_WIDTH, a gray2bin function, and a bin2gray function (also used by the pointer blocks).
- One natural sub-module: fifo_skid_buf (2-entry valid/ready skid buffer, DATA_WIDTH parameter).
- Level/almost-full logic and push counter stay in the top.

Test Plan:
- Reset: hold W_RST=0 with s_valid=1 -> s_ready=0, w_inc=0, w_level=0, w_push_cnt=0. Release -> s_ready=1 next edge.
- Streaming: s_valid=1 for 8 words 0x10..0x17, w_full=0 -> w_inc high 8 consecutive cycles starting 1 cycle after the first accept; w_wdata=0x10..0x17 in order; w_push_cnt=8.
- Backpressure: w_full=1 while 3 words are offered -> 2 accepted, s_ready=0, w_inc=0. Drop w_full -> those 2 words pushed in order, then the 3rd accepted.
- Simultaneous: count=1, accept and push in the same cycle -> count stays 1, w_wdata advances to the next word, no loss.
- Level/wrap: w_ptr=gray(9)=4'b1101, wq2_rptr=gray(3)=4'b0010 -> w_level=6, w_almost_full=1. w_ptr=gray(1), wq2_rptr=gray(14) -> w_level=3, w_almost_full=0.
- Mid-burst reset: assert W_RST with count=2 -> buffer empties, w_inc=0 immediately, w_push_cnt=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer geometry helpers and Gray/binary conversion
// used by the write front end and the pointer blocks.
package fifo_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 3;
   localparam int PTR_WIDTH_MAX      = 16;
   localparam int SKID_DEPTH         = 2;

   typedef logic [PTR_WIDTH_MAX-1:0] ptr_t;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int ptr_width_of(input int addr_width);
      return addr_width + 1;
   endfunction

   // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t bin;
      bin = gray;
      for (int s = 1; s < PTR_WIDTH_MAX; s = s * 2) begin
         bin = bin ^ (bin >> s);
      end
      return bin;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready skid buffer; the output side pops whenever it holds data
// and the downstream is not stalled, independent of the incoming valid.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  W_CLK,
   input  logic                  W_RST,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  stall,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [DATA_WIDTH-1:0] entry [SKID_DEPTH];
   logic                  head;
   logic                  tail;
   logic [1:0]            count;
   logic [1:0]            count_next;
   logic                  accept;
   logic                  pop;

   assign accept    = in_valid & in_ready;
   assign pop       = (count != 2'd0) & ~stall;
   assign out_valid = pop;
   assign out_data  = entry[head];

   always_comb begin
      count_next = count;
      case ({accept, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // Ready is registered from the next occupancy so it never depends on in_valid.
   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         entry[0] <= '0;
         entry[1] <= '0;
         head     <= 1'b0;
         tail     <= 1'b0;
         count    <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         if (accept) begin
            entry[tail] <= in_data;
            tail        <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         count    <= count_next;
         in_ready <= (count_next < 2'd2);
      end
   end

endmodule

// File: rtl/fifo_wr_stream_if.sv
// Write-side stream front end of the async FIFO: skid-buffered push path plus
// write-domain fill level, almost-full flag and push counter.
module fifo_wr_stream_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int AF_THRESH  = 6
) (
   input  logic                  W_CLK,
   input  logic                  W_RST,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  w_full,
   input  logic [ADDR_WIDTH:0]   w_ptr,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic                  w_inc,
   output logic [DATA_WIDTH-1:0] w_wdata,
   output logic [ADDR_WIDTH:0]   w_level,
   output logic                  w_almost_full,
   output logic [15:0]           w_push_cnt
);

   localparam int                   PTR_WIDTH = ptr_width_of(ADDR_WIDTH);
   localparam logic [PTR_WIDTH-1:0] AF_LEVEL  = PTR_WIDTH'(AF_THRESH);

   logic [PTR_WIDTH-1:0] wbin;
   logic [PTR_WIDTH-1:0] rbin;
   logic [PTR_WIDTH-1:0] level_c;

   fifo_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) skid (
      .W_CLK    (W_CLK),
      .W_RST    (W_RST),
      .in_data  (s_data),
      .in_valid (s_valid),
      .in_ready (s_ready),
      .stall    (w_full),
      .out_valid(w_inc),
      .out_data (w_wdata)
   );

   // Modular subtraction keeps the level right across pointer wrap; the stale
   // read pointer can only make it over-report.
   assign wbin    = PTR_WIDTH'(gray2bin(ptr_t'(w_ptr)));
   assign rbin    = PTR_WIDTH'(gray2bin(ptr_t'(wq2_rptr)));
   assign level_c = wbin - rbin;

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         w_level       <= '0;
         w_almost_full <= 1'b0;
         w_push_cnt    <= 16'd0;
      end else begin
         w_level       <= level_c;
         w_almost_full <= (level_c >= AF_LEVEL);
         if (w_inc) begin
            w_push_cnt <= w_push_cnt + 16'd1;
         end
      end
   end

endmodule
